// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat line burst protocol: stores whole lines,
// delays each request by LATENCY cycles, then streams BEATS beats, flagging protocol misuse.
module burst_mem_responder #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BEAT_W      = 64,
  parameter int unsigned BEATS       = 4,
  parameter int unsigned DEPTH_LINES = 256,
  parameter int unsigned LATENCY     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic              resp_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned IDX_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned TAG_W = ADDR_W - 5;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t             state_q, state_d;
  logic [LW-1:0]      lat_q, lat_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic               op_wr_q, op_wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [BEAT_W-1:0]  burst_d;
  logic               resp_d, busy_d, err_d;
  logic               mem_we, viol;

  logic [BEAT_W-1:0]  mem [DEPTH_LINES][BEATS];

  // Byte offset within the line carries no meaning here.
  logic offset_unused;
  assign offset_unused = ^address_i[4:0];

  assign viol = (op_wr_q ? !write_i : !read_i) ||
                (op_wr_q ? read_i : write_i) ||
                (address_i[ADDR_W-1:5] != tag_q);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    burst_d = '0;
    resp_d  = 1'b0;
    err_d   = err_o;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_i && write_i) begin
          err_d = 1'b1;
        end else if (read_i || write_i) begin
          op_wr_d = write_i;
          idx_d   = address_i[5 +: IDX_W];
          tag_d   = address_i[ADDR_W-1:5];
          lat_d   = LW'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (viol) err_d = 1'b1;
        if (lat_q == '0) begin
          state_d = BURST;
          beat_d  = '0;
          resp_d  = 1'b1;
          if (!op_wr_q) burst_d = mem[idx_q][0];
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      BURST: begin
        if (viol) err_d = 1'b1;
        mem_we = op_wr_q;
        if (beat_q == BW'(BEATS - 1)) begin
          state_d = DONE;
        end else begin
          beat_d = beat_q + 1'b1;
          resp_d = 1'b1;
          if (!op_wr_q) burst_d = mem[idx_q][beat_d];
        end
      end
      DONE: begin
        if (!read_i && !write_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      tag_q   <= '0;
      burst_o <= '0;
      resp_o  <= 1'b0;
      busy_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      burst_o <= burst_d;
      resp_o  <= resp_d;
      busy_o  <= busy_d;
      err_o   <= err_d;
    end
  end

  // Write enable derives from the async-reset state, so a reset mid-burst stops commits at once.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q][beat_q] <= burst_i;
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: line model plus a read-beat scoreboard queue.
module tb_burst_mem_responder;

  localparam int unsigned LATENCY = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_i, write_i;
  logic [31:0] address_i;
  logic [63:0] burst_i, burst_o;
  logic        resp_o, busy_o, err_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [256][4];
  logic [63:0] exp_q [$];

  burst_mem_responder #(
    .ADDR_W(32), .BEAT_W(64), .BEATS(4), .DEPTH_LINES(256), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .burst_i(burst_i), .burst_o(burst_o),
    .resp_o(resp_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // drop_at: beat index at which read_i is released early; rst_at: beat at which rst is pulsed.
  task automatic xfer(input bit is_wr, input logic [31:0] addr,
                      input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3,
                      input int drop_at, input int rst_at);
    logic [63:0] d [4];
    logic [7:0]  idx;
    logic [63:0] e;
    int          n;
    d[0] = {8{b0}}; d[1] = {8{b1}}; d[2] = {8{b2}}; d[3] = {8{b3}};
    idx = addr[12:5];
    if (!is_wr) for (int k = 0; k < 4; k++) exp_q.push_back(model[idx][k]);
    read_i = !is_wr; write_i = is_wr; address_i = addr;
    tick();
    check("busy_accept", 64'(busy_o), 64'd1);
    n = 0;
    while (!resp_o && n < 40) begin
      check("resp_in_wait", 64'(resp_o), 64'd0);
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(LATENCY));
    for (int k = 0; k < 4; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_resp", 64'(resp_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        rst = 1'b0; read_i = 1'b0; write_i = 1'b0; burst_i = '0;
        tick();
        return;
      end
      if (k == drop_at) read_i = 1'b0;
      check("resp_beat", 64'(resp_o), 64'd1);
      if (is_wr) begin
        burst_i = d[k];
        model[idx][k] = d[k];
      end else begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check("rd_beat", burst_o, e);
      end
      tick();
    end
    check("resp_end", 64'(resp_o), 64'd0);
    check("burst_end", burst_o, 64'd0);
    check("busy_done", 64'(busy_o), 64'd1);
    read_i = 1'b0; write_i = 1'b0; burst_i = '0;
    tick();
    check("busy_idle", 64'(busy_o), 64'd0);
    check("resp_idle", 64'(resp_o), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0; burst_i = '0;
    tick(); tick();
    check("rst_resp0", 64'(resp_o), 64'd0);
    check("rst_burst0", burst_o, 64'd0);
    check("rst_busy0", 64'(busy_o), 64'd0);
    check("rst_err0", 64'(err_o), 64'd0);
    rst = 1'b0;
    tick();

    xfer(1'b1, 32'h0000_0040, 8'h11, 8'h22, 8'h33, 8'h44, -1, -1);
    check("err_wr", 64'(err_o), 64'd0);
    xfer(1'b0, 32'h0000_0040, 8'h00, 8'h00, 8'h00, 8'h00, -1, -1);
    check("err_rd", 64'(err_o), 64'd0);

    xfer(1'b1, 32'h0000_2040, 8'hA1, 8'hB2, 8'hC3, 8'hD4, -1, -1);
    xfer(1'b0, 32'h0000_005F, 8'h00, 8'h00, 8'h00, 8'h00, -1, -1);
    check("err_alias", 64'(err_o), 64'd0);

    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_0040;
    tick();
    check("both_err", 64'(err_o), 64'd1);
    check("both_resp", 64'(resp_o), 64'd0);
    check("both_busy", 64'(busy_o), 64'd0);
    tick();
    check("both_busy2", 64'(busy_o), 64'd0);
    check("both_resp2", 64'(resp_o), 64'd0);
    read_i = 1'b0; write_i = 1'b0;
    tick();
    xfer(1'b0, 32'h0000_0040, 8'h00, 8'h00, 8'h00, 8'h00, -1, -1);
    check("both_err_sticky", 64'(err_o), 64'd1);

    rst = 1'b1;
    #1;
    check("rst_clr_err", 64'(err_o), 64'd0);
    rst = 1'b0;
    tick();
    xfer(1'b0, 32'h0000_0040, 8'h00, 8'h00, 8'h00, 8'h00, 2, -1);
    check("drop_err", 64'(err_o), 64'd1);

    xfer(1'b1, 32'h0000_0080, 8'h55, 8'h55, 8'h55, 8'h55, -1, -1);
    xfer(1'b1, 32'h0000_0080, 8'hAA, 8'hAA, 8'hAA, 8'hAA, -1, 2);
    check("midrst_err", 64'(err_o), 64'd0);
    xfer(1'b0, 32'h0000_0080, 8'h00, 8'h00, 8'h00, 8'h00, -1, -1);
    check("midrst_rd_err", 64'(err_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
- Responder end of the 64-bit, 4-beat physical-memory burst protocol driven by the cache hierarchy's line adaptor (read/write/address out, burst data both ways, resp in).
- Stands in for main memory in synthesizable and standalone benches.
- Stores whole 256-bit lines in an internal array, inserts a programmable access latency, and flags protocol violations.

Parameters:
- ADDR_W, 32, request address width.
- BEAT_W, 64, data width of one beat.
- BEATS, 4, beats per line; line = BEATS*BEAT_W bits.
- DEPTH_LINES, 256, number of stored lines; power of two.
- LATENCY, 8, cycles from request acceptance to first beat; must be >= 1.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- read_i, in, 1, host line-read request; held high until the final resp_o beat.
- write_i, in, 1, host line-write request; held high until the final resp_o beat.
- address_i, in, ADDR_W, line address. Bits [4:0] are ignored. Index = address_i[5 +: log2(DEPTH_LINES)]; upper bits alias.
- burst_i, in, BEAT_W, write beat from host; beat k is sampled in the cycle resp_o is high for beat k.
- burst_o, out, BEAT_W, read beat to host; valid when resp_o is high.
- resp_o, out, 1, per-beat response; high for exactly BEATS consecutive cycles per transaction.
- busy_o, out, 1, high in every state except IDLE.
- err_o, out, 1, sticky protocol-error flag; cleared only by rst.

Behaviour:
- Reset: state=IDLE, resp_o=0, burst_o=0, busy_o=0, err_o=0, beat and latency counters=0. Array contents are not reset.
- All outputs are registered.
- States: IDLE, WAIT, BURST, DONE.
- IDLE:
  - Exactly one of read_i/write_i high: latch op, index and address_i; go to WAIT with lat_cnt=LATENCY-1.
  - Both high: set err_o, stay in IDLE, no array access.
- WAIT:
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0, go to BURST with beat=0 and resp_o=1 in the next cycle.
  - First resp_o is therefore exactly LATENCY cycles after the acceptance cycle.
- BURST:
  - resp_o=1 every cycle; beat increments 0..BEATS-1.
  - Read: burst_o = line[beat*BEAT_W +: BEAT_W]. Beat 0 is the least-significant 64 bits.
  - Write: line[beat*BEAT_W +: BEAT_W] <= burst_i at the end of each resp_o cycle.
  - After beat BEATS-1, go to DONE; resp_o=0 and burst_o=0 next cycle.
- DONE:
  - Stay while read_i or write_i is high.
  - Go to IDLE once both are low. The host must deassert for at least 1 cycle, so there are no back-to-back transactions without a gap.
- Violations (set err_o; transaction still runs to completion):
  - In WAIT or BURST: the latched request is dropped, the opposite request is raised, or address_i[31:5] differs from the latched value.
  - Writes still commit all beats using whatever burst_i holds.
- Read-after-write to the same line returns the newly written data. The write commits before DONE, so no hazard is possible.
- rst asserted mid-transaction:
  - Immediately forces IDLE and clears resp_o.
  - Beats already written stay written; unwritten beats keep old contents.
- resp_o never asserts in IDLE, WAIT or DONE.

Test Plan:
- Write, LATENCY=8: write_i, address 0x00000040, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> resp_o rises exactly 8 cycles after acceptance, stays high 4 cycles, then busy_o drops after write_i falls; err_o=0.
- Read-back: read_i at 0x00000040 -> burst_o delivers 0x11..11, 0x22..22, 0x33..33, 0x44..44 in order on 4 consecutive resp_o cycles; 0 otherwise.
- Aliasing and offset: write at 0x00002040, then read at 0x0000005F with DEPTH_LINES=256 -> reads return the 0x00002040 data (bits [4:0] ignored, index 2 wraps).
- Both requests: read_i and write_i high together in IDLE -> err_o=1 next cycle, resp_o stays 0, state stays IDLE; a later legal request still completes.
- Mid-burst drop: deassert read_i after the 2nd resp_o beat -> err_o=1, resp_o still completes 4 beats, then IDLE.
- Reset mid-write: assert rst after beat 1 of a write of all-0xAA beats over a line previously holding all-0x55 -> resp_o=0 immediately; a subsequent read returns 0xAA.., 0xAA.., 0x55.., 0x55...
